main_memory_responder: RTL and testbench

- Backing data-memory responder on the far side of the cache controller's memory interface.
- Serves two request types, each held on a level until done:
  - rd_en_dm: block refill, one cache line returned as a word burst.
  - wr_en_dm: write-through of a single word.
- Models main-memory latency with programmable wait counters and signals completion with a single-cycle done pulse.
- Data returned during a refill is written into the cache line by the cache side.

---
 rtl/mem_if_pkg.sv | 16 +
 rtl/mem_array.sv | 24 ++
 rtl/main_memory_responder.sv | 130 +++++++++++++
 tb/tb_main_memory_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions: responder state encoding and the
// default geometry used by the cache controller, cache array and responder.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RD_WAIT  = 2'b01,
    RD_BURST = 2'b10,
    WR_WAIT  = 2'b11
  } mem_state_t;

  localparam int unsigned DEF_ADDR_W          = 10;
  localparam int unsigned DEF_DATA_W          = 32;
  localparam int unsigned DEF_WORDS_PER_BLOCK = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port main-memory storage: synchronous write, combinational read.
// Contents start at zero and are deliberately untouched by reset.
module mem_array #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory responder: serves cache-line refills as word bursts and
// single-word write-throughs after programmable latencies, with a done pulse.
module main_memory_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int unsigned RD_LATENCY      = 4,
  parameter int unsigned WR_LATENCY      = 4,
  localparam int unsigned IDX_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_dm,
  input  logic              wr_en_dm,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic [IDX_W-1:0]  word_idx,
  output logic              done,
  output logic              busy
);

  localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(WORDS_PER_BLOCK - 1);

  mem_state_t        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] addr_q;     // write address, or aligned line base for reads
  logic [DATA_W-1:0] wdata_q;
  logic [IDX_W-1:0]  idx_inc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              accept_slot;

  assign idx_inc = word_idx + IDX_W'(1);
  assign mem_we  = (state == WR_WAIT) && (wait_cnt == '0);

  // The edge closing the last burst word doubles as an acceptance edge so
  // back-to-back requests lose no cycle after done.
  assign accept_slot = (state == IDLE) || ((state == RD_BURST) && (word_idx == LAST_IDX));

  // Base is line-aligned, so adding the offset never carries out of the line.
  always_comb begin
    mem_addr = addr_q;
    if (state == RD_BURST) mem_addr = addr_q + ADDR_W'(idx_inc);
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      word_idx    <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RD_WAIT: begin
          if (wait_cnt == '0) begin
            state       <= RD_BURST;
            rdata       <= mem_rdata;
            rdata_valid <= 1'b1;
            word_idx    <= '0;
            done        <= (WORDS_PER_BLOCK == 1);
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        RD_BURST: begin
          if (word_idx != LAST_IDX) begin
            word_idx <= idx_inc;
            rdata    <= mem_rdata;
            done     <= (idx_inc == LAST_IDX);
          end
        end
        WR_WAIT: begin
          if (wait_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase

      if (accept_slot) begin
        rdata_valid <= 1'b0;
        if (wr_en_dm) begin
          state    <= WR_WAIT;
          busy     <= 1'b1;
          addr_q   <= addr;
          wdata_q  <= wdata;
          wait_cnt <= CNT_W'(WR_LATENCY - 1);
        end else if (rd_en_dm) begin
          state    <= RD_WAIT;
          busy     <= 1'b1;
          addr_q   <= addr & BASE_MASK;
          wait_cnt <= CNT_W'(RD_LATENCY - 1);
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: directed table, reset
// corner cases, randomized traffic against an array model, and a 1-word/1-cycle instance.
module tb_main_memory_responder;

  localparam int unsigned AW = 10, DW = 32, WPB = 4, RDL = 4, WRL = 4;
  localparam int DONE_K = RDL + WPB - 1;

  logic clk = 1'b0;
  logic rst;
  logic rd_en_dm, wr_en_dm;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic rdata_valid, done, busy;
  logic [1:0] word_idx;

  logic rd2, wr2;
  logic [AW-1:0] addr2;
  logic [DW-1:0] wdata2, rdata2;
  logic valid2, done2, busy2;
  logic [0:0] idx2;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] ref_mem [1 << AW];
  logic [DW-1:0] exp_rdata;

  typedef struct {
    bit                     is_wr;
    bit                     keep_rd;
    logic [AW-1:0]          a;
    logic [DW-1:0]          d;
    int                     drop_k;
    logic [WPB-1:0][DW-1:0] exp_w;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  main_memory_responder #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WPB), .RD_LATENCY(RDL), .WR_LATENCY(WRL)
  ) dut (
    .clk(clk), .rst(rst), .rd_en_dm(rd_en_dm), .wr_en_dm(wr_en_dm), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .word_idx(word_idx),
    .done(done), .busy(busy)
  );

  main_memory_responder #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(1), .RD_LATENCY(1), .WR_LATENCY(WRL)
  ) dut2 (
    .clk(clk), .rst(rst), .rd_en_dm(rd2), .wr_en_dm(wr2), .addr(addr2),
    .wdata(wdata2), .rdata(rdata2), .rdata_valid(valid2), .word_idx(idx2),
    .done(done2), .busy(busy2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] obs();
    return {27'd0, rdata_valid, done, busy, (rdata_valid ? word_idx : 2'd0), rdata};
  endfunction

  function automatic logic [63:0] expv(input bit v, input bit d, input bit b, input int idx,
                                       input logic [DW-1:0] data);
    return {27'd0, v, d, b, (v ? 2'(idx) : 2'd0), data};
  endfunction

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep_rd,
                          input string tag);
    wr_en_dm = 1'b1;
    addr     = a;
    wdata    = d;
    if (keep_rd) rd_en_dm = 1'b1;
    for (int k = 0; k <= WRL; k++) begin
      step();
      chk($sformatf("%s wr k%0d", tag, k), obs(), expv(1'b0, k == WRL, k < WRL, 0, exp_rdata));
      if (k == WRL) begin
        wr_en_dm  = 1'b0;
        ref_mem[a] = d;
      end else begin
        addr  = AW'($urandom);
        wdata = $urandom;
      end
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int drop_k,
                         input logic [WPB-1:0][DW-1:0] exp_w, input string tag);
    bit v;
    int w;
    rd_en_dm = 1'b1;
    addr     = a;
    for (int k = 0; k <= RDL + WPB; k++) begin
      step();
      v = (k >= RDL) && (k < RDL + WPB);
      w = k - RDL;
      if (v) exp_rdata = exp_w[w];
      chk($sformatf("%s rd k%0d", tag, k), obs(),
          expv(v, v && (w == WPB - 1), k < RDL + WPB, w, exp_rdata));
      if (k == drop_k || k == DONE_K) rd_en_dm = 1'b0;
      addr = AW'($urandom);
    end
  endtask

  task automatic model_line(input logic [AW-1:0] a, output logic [WPB-1:0][DW-1:0] line);
    logic [AW-1:0] base;
    base = a & ~AW'(WPB - 1);
    for (int i = 0; i < WPB; i++) line[i] = ref_mem[base + AW'(i)];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    logic [WPB-1:0][DW-1:0] line;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd_data;

    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    exp_rdata = '0;
    rst = 1'b1; rd_en_dm = 1'b0; wr_en_dm = 1'b0; addr = '0; wdata = '0;
    rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; wdata2 = '0;

    tbl[0] = '{1'b1, 1'b0, 10'h005, 32'hDEADBEEF, 0, '0};
    tbl[1] = '{1'b0, 1'b0, 10'h006, 32'h0, DONE_K, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}};
    tbl[2] = '{1'b0, 1'b0, 10'h006, 32'h0, 1, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}};
    tbl[3] = '{1'b1, 1'b1, 10'h010, 32'h12345678, 0, '0};
    tbl[4] = '{1'b0, 1'b0, 10'h010, 32'h0, DONE_K, {32'h0, 32'h0, 32'h0, 32'h12345678}};
    tbl[5] = '{1'b1, 1'b0, 10'h3FF, 32'hA5A5A5A5, 0, '0};
    tbl[6] = '{1'b0, 1'b0, 10'h3FD, 32'h0, DONE_K, {32'hA5A5A5A5, 32'h0, 32'h0, 32'h0}};
    tbl[7] = '{1'b1, 1'b0, 10'h3FC, 32'h11112222, 0, '0};
    tbl[8] = '{1'b0, 1'b0, 10'h3FF, 32'h0, 2, {32'hA5A5A5A5, 32'h0, 32'h0, 32'h11112222}};

    // Reset then idle
    step(); step();
    chk("in reset", obs(), expv(1'b0, 1'b0, 1'b0, 0, '0));
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("idle c%0d", k), obs(), expv(1'b0, 1'b0, 1'b0, 0, '0));
    end

    // Directed table
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].is_wr) do_write(tbl[i].a, tbl[i].d, tbl[i].keep_rd, $sformatf("t%0d", i));
      else              do_read(tbl[i].a, tbl[i].drop_k, tbl[i].exp_w, $sformatf("t%0d", i));
    end

    // Reset during burst word 1: immediate abort, array intact
    rd_en_dm = 1'b1;
    addr = 10'h006;
    for (int k = 0; k <= RDL + 1; k++) step();
    chk("burst at idx1", {61'd0, rdata_valid, word_idx}, {61'd0, 1'b1, 2'd1});
    #2 rst = 1'b1;
    #1 chk("async rst mid-burst", obs(), expv(1'b0, 1'b0, 1'b0, 0, '0));
    exp_rdata = '0;
    rd_en_dm = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("after burst rst c%0d", k), obs(), expv(1'b0, 1'b0, 1'b0, 0, '0));
    end
    do_read(10'h006, DONE_K, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, "reread");

    // Reset during write wait: write must not commit
    wr_en_dm = 1'b1;
    addr = 10'h005;
    wdata = 32'hBADBAD00;
    step(); step();
    #2 rst = 1'b1;
    #1 chk("async rst mid-write", obs(), expv(1'b0, 1'b0, 1'b0, 0, '0));
    exp_rdata = '0;
    wr_en_dm = 1'b0;
    step();
    rst = 1'b0;
    step();
    do_read(10'h004, DONE_K, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, "no-commit");

    // Randomized traffic against the array model
    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 1) != 0 ? 10'h3E0 : 10'h000) | AW'($urandom_range(0, 31));
      if ($urandom_range(0, 1) != 0) begin
        do_write(ra, $urandom, 1'b0, $sformatf("r%0d", n));
      end else begin
        model_line(ra, line);
        do_read(ra, $urandom_range(0, DONE_K), line, $sformatf("r%0d", n));
      end
    end

    // One-word line, one-cycle latency: continuous request gives done every 2 cycles
    wr2 = 1'b1;
    addr2 = 10'h003;
    wdata2 = 32'h00000077;
    for (int k = 0; k <= WRL; k++) begin
      step();
      if (k == WRL) begin
        chk("dut2 write done", {63'd0, done2}, 64'd1);
        wr2 = 1'b0;
      end
    end
    rd_data = 32'h00000077;
    rd2 = 1'b1;
    step();
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("b2b k%0d", k), {29'd0, valid2, done2, busy2, (valid2 ? rdata2 : 32'h0)},
          {29'd0, (k % 2) == 1, (k % 2) == 1, 1'b1, ((k % 2) == 1 ? rd_data : 32'h0)});
    end
    rd2 = 1'b0;
    step(); step(); step();
    chk("dut2 idle", {62'd0, busy2, done2}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
